// File: rtl/mux_arb_pkg.sv
// Shared constants for the 4-way round-robin word arbiter: requester count
// and the two-state output register encoding.
package mux_arb_pkg;

  localparam int unsigned NREQ = 4;

  localparam logic STATE_IDLE = 1'b0;
  localparam logic STATE_HOLD = 1'b1;

endpackage

// File: rtl/rr_pick4.sv
// Combinational round-robin search: first set req bit starting at ptr+1,
// wrapping modulo 4.
module rr_pick4
  import mux_arb_pkg::*;
(
  input  logic [NREQ-1:0] req,
  input  logic [1:0]      ptr,
  output logic            any,
  output logic [1:0]      idx,
  output logic [NREQ-1:0] onehot
);

  logic [1:0] cand_s;

  // Walk offsets from farthest to nearest so the nearest hit wins.
  always_comb begin
    any    = 1'b0;
    idx    = 2'b00;
    cand_s = 2'b00;
    for (int k = NREQ; k >= 1; k--) begin
      cand_s = ptr + k[1:0];
      if (req[cand_s]) begin
        any = 1'b1;
        idx = cand_s;
      end else begin
        any = any;
      end
    end
    if (any) begin
      onehot = 4'b0001 << idx;
    end else begin
      onehot = 4'b0000;
    end
  end

endmodule

// File: rtl/mux4_rr_arbiter.sv
// Four-requester round-robin arbiter feeding a single registered output
// word with valid/ready handshake and back-to-back capture.
module mux4_rr_arbiter
  import mux_arb_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [NREQ-1:0]       req,
  input  logic [NREQ*WIDTH-1:0] din,
  output logic [NREQ-1:0]       gnt,
  output logic [1:0]            sel,
  output logic [WIDTH-1:0]      dout,
  output logic                  dout_valid,
  input  logic                  dout_ready
);

  logic             state_r;
  logic [1:0]       ptr_r;
  logic [1:0]       sel_r;
  logic [WIDTH-1:0] dout_r;

  logic             any_s;
  logic [1:0]       idx_s;
  logic [NREQ-1:0]  onehot_s;
  logic             can_capture_s;
  logic             capture_s;
  logic [WIDTH-1:0] word_s;

  rr_pick4 u_pick (
    .req    (req),
    .ptr    (ptr_r),
    .any    (any_s),
    .idx    (idx_s),
    .onehot (onehot_s)
  );

  // Capture is possible when the output slot is empty or is being drained.
  always_comb begin
    can_capture_s = (state_r == STATE_IDLE) | dout_ready;
    capture_s     = can_capture_s & any_s;
    word_s        = din[int'(idx_s)*WIDTH +: WIDTH];
    // rst_n gates gnt so no accept is advertised while reset is held.
    if (capture_s && rst_n) begin
      gnt = onehot_s;
    end else begin
      gnt = 4'b0000;
    end
  end

  // Output register, fairness pointer and IDLE/HOLD state.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r <= STATE_IDLE;
      ptr_r   <= 2'b11;
      sel_r   <= 2'b00;
      dout_r  <= {WIDTH{1'b0}};
    end else if (capture_s) begin
      state_r <= STATE_HOLD;
      ptr_r   <= idx_s;
      sel_r   <= idx_s;
      dout_r  <= word_s;
    end else if ((state_r == STATE_HOLD) && dout_ready) begin
      state_r <= STATE_IDLE;
    end else begin
      state_r <= state_r;
    end
  end

  assign sel        = sel_r;
  assign dout       = dout_r;
  assign dout_valid = (state_r == STATE_HOLD);

endmodule

// File: tb/tb_mux4_rr_arbiter.sv
// Self-checking bench for mux4_rr_arbiter: directed scenarios followed by
// randomized traffic against a behavioural round-robin model.
module tb_mux4_rr_arbiter;

  logic        clk;
  logic        rst_n;
  logic [3:0]  req;
  logic [31:0] din;
  logic [3:0]  gnt;
  logic [1:0]  sel;
  logic [7:0]  dout;
  logic        dout_valid;
  logic        dout_ready;

  int n_checks = 0;
  int n_fails  = 0;

  // model state
  int          m_valid;
  int          m_ptr;
  int          m_sel;
  logic [7:0]  m_dout;

  mux4_rr_arbiter #(.WIDTH(8)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .req        (req),
    .din        (din),
    .gnt        (gnt),
    .sel        (sel),
    .dout       (dout),
    .dout_valid (dout_valid),
    .dout_ready (dout_ready)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic int pick(input logic [3:0] r, input int p);
    for (int k = 1; k <= 4; k++) begin
      if (r[(p + k) % 4]) return (p + k) % 4;
    end
    return -1;
  endfunction

  task automatic model_reset();
    m_valid = 0;
    m_ptr   = 3;
    m_sel   = 0;
    m_dout  = 8'h00;
  endtask

  // One clock: drive at negedge, check gnt, then check registers after the edge.
  task automatic step(input logic [3:0] r, input logic [31:0] d, input logic rdy);
    int w;
    logic [3:0] eg;
    @(negedge clk);
    req = r; din = d; dout_ready = rdy;
    #1;
    w  = ((m_valid == 0) || rdy) ? pick(r, m_ptr) : -1;
    eg = (w >= 0) ? (4'b0001 << w) : 4'b0000;
    chk("gnt", {28'h0, gnt}, {28'h0, eg});
    @(posedge clk);
    if (w >= 0) begin
      m_dout  = d[w*8 +: 8];
      m_sel   = w;
      m_ptr   = w;
      m_valid = 1;
    end else if (m_valid != 0 && rdy) begin
      m_valid = 0;
    end
    #1;
    chk("dout_valid", {31'h0, dout_valid}, m_valid[31:0]);
    chk("sel", {30'h0, sel}, m_sel[31:0]);
    chk("dout", {24'h0, dout}, {24'h0, m_dout});
  endtask

  task automatic do_reset();
    @(negedge clk);
    req = 4'b1111; din = 32'h0; dout_ready = 1'b1;
    rst_n = 1'b0;
    #1;
    model_reset();
    chk("rst_gnt", {28'h0, gnt}, 32'h0);
    chk("rst_valid", {31'h0, dout_valid}, 32'h0);
    chk("rst_dout", {24'h0, dout}, 32'h0);
    chk("rst_sel", {30'h0, sel}, 32'h0);
    @(posedge clk);
    #2 rst_n = 1'b1;
  endtask

  initial begin
    logic [7:0] exp_seq [5];
    logic [7:0] held;
    logic [1:0] held_sel;
    rst_n = 1'b1; req = 4'b0; din = 32'h0; dout_ready = 1'b0;
    model_reset();

    // single requester, first capture right after reset
    do_reset();
    step(4'b0001, 32'h000000A5, 1'b1);
    chk("r028_dout", {24'h0, dout}, 32'hA5);
    chk("r028_sel", {30'h0, sel}, 32'h0);
    chk("r028_valid", {31'h0, dout_valid}, 32'h1);

    // all four requesting: rotation without bubbles
    do_reset();
    exp_seq[0] = 8'h11; exp_seq[1] = 8'h22; exp_seq[2] = 8'h33;
    exp_seq[3] = 8'h44; exp_seq[4] = 8'h11;
    for (int i = 0; i < 5; i++) begin
      step(4'b1111, 32'h44332211, 1'b1);
      chk("r029_dout", {24'h0, dout}, {24'h0, exp_seq[i]});
      chk("r029_valid", {31'h0, dout_valid}, 32'h1);
    end

    // backpressure holds the word, then requester 1 follows
    do_reset();
    step(4'b0001, 32'h44332211, 1'b1);
    held = dout; held_sel = sel;
    chk("r030_first", {24'h0, held}, 32'h11);
    for (int i = 0; i < 5; i++) begin
      step(4'b1110, 32'h44332211, 1'b0);
      chk("r030_stable_dout", {24'h0, dout}, {24'h0, held});
      chk("r030_stable_sel", {30'h0, sel}, {30'h0, held_sel});
    end
    step(4'b1110, 32'h44332211, 1'b1);
    chk("r030_next", {24'h0, dout}, 32'h22);

    // lone requester 2 regranted each cycle, then drain
    for (int i = 0; i < 4; i++) begin
      step(4'b0100, {8'h00, 8'h50 + 8'(i), 16'h0}, 1'b1);
      chk("r031_sel", {30'h0, sel}, 32'h2);
      chk("r031_valid", {31'h0, dout_valid}, 32'h1);
    end
    step(4'b0000, 32'h0, 1'b1);
    chk("r031_drop", {31'h0, dout_valid}, 32'h0);
    chk("r031_keep_sel", {30'h0, sel}, 32'h2);

    // asynchronous reset pulse while holding a word
    step(4'b0010, 32'h0000BB00, 1'b0);
    step(4'b0010, 32'h0000BB00, 1'b0);
    @(posedge clk);
    #2;
    req = 4'b1111; dout_ready = 1'b1;
    rst_n = 1'b0;
    #1;
    model_reset();
    chk("r032_valid", {31'h0, dout_valid}, 32'h0);
    chk("r032_sel", {30'h0, sel}, 32'h0);
    chk("r032_dout", {24'h0, dout}, 32'h0);
    chk("r032_gnt", {28'h0, gnt}, 32'h0);
    #1 rst_n = 1'b1;
    step(4'b1111, 32'hDDCCBBAA, 1'b1);
    chk("r032_first", {30'h0, sel}, 32'h0);

    // randomized traffic against the model
    for (int i = 0; i < 400; i++) begin
      step(4'($urandom_range(0, 15)), $urandom, ($urandom_range(0, 3) != 0));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end

endmodule

// File: doc/mux4_rr_arbiter.md
MUX4_RR_ARBITER -- requirements
Module: mux4_rr_arbiter

Interface
REQ-001 Parameter: WIDTH, default 8, data word width per requester.
REQ-002 Port: clk  in  1  single clock, all state on rising edge.
REQ-003 Port: rst_n  in  1  reset, asynchronous, active-low.
REQ-004 Port: req  in  4  per-requester valid; bit i = requester i has a word.
REQ-005 Port: din  in  4*WIDTH  requester words; din[i*WIDTH +: WIDTH] belongs to requester i.
REQ-006 Port: gnt  out  4  one-hot combinational accept; req[i]&gnt[i] = word i captured at next edge.
REQ-007 Port: sel  out  2  registered index of the requester whose word is in dout.
REQ-008 Port: dout  out  WIDTH  registered selected word.
REQ-009 Port: dout_valid  out  1  dout holds an unconsumed word.
REQ-010 Port: dout_ready  in  1  downstream accepts; transfer = dout_valid&dout_ready.

Function
REQ-011 Two states SHALL exist: IDLE (dout_valid=0) and HOLD (dout_valid=1).
REQ-012 The block SHALL be able to capture a word when state==IDLE, or when state==HOLD and dout_ready=1.
REQ-013 When able to capture and req!=0, winner SHALL be the first set req bit searched from ptr+1 upward, modulo 4.
REQ-014 gnt SHALL be one-hot at winner while a capture is possible and req!=0, else 4'b0000; never more than one bit set.
REQ-015 On capture edge: dout<=din[winner], sel<=winner, ptr<=winner, state<=HOLD (single-cycle latency req->dout_valid).
REQ-016 In HOLD with dout_ready=0: dout, sel, dout_valid SHALL stay stable; gnt=0; req changes ignored.
REQ-017 In HOLD with dout_ready=1 and req==0: state<=IDLE, dout_valid falls next cycle; dout, sel retain last value.
REQ-018 In HOLD with dout_ready=1 and req!=0: back-to-back capture per REQ-015, dout_valid stays 1 with no bubble.
REQ-019 A requester held high alone SHALL be granted every capture opportunity; with all four high, grants SHALL rotate 0,1,2,3,0.
REQ-020 dout_ready in IDLE SHALL be ignored.
REQ-021 ptr SHALL update only on capture; wrap 3->0 is natural modulo-4.

Reset
REQ-022 On rst_n low, asynchronously: state=IDLE, dout_valid=0, dout=0, sel=2'b00, ptr=2'b11 (requester 0 wins first).
REQ-023 Reset mid-HOLD SHALL discard the held word; gnt SHALL be 0 while rst_n is low.
REQ-024 First capture SHALL be possible on the first rising edge after rst_n deasserts.

Structure
REQ-025 State encoding (IDLE=1'b0, HOLD=1'b1) and requester count 4 SHALL live in shared package mux_arb_pkg.
REQ-026 Round-robin search SHALL be a combinational sub-module rr_pick4 (inputs req[3:0], ptr[1:0]; outputs any, idx[1:0], onehot[3:0]).
REQ-027 Datapath SHALL be a WIDTH-wide 4:1 word select indexed by winner, registered into dout.

Verification
REQ-028 Reset, then req=4'b0001, din word0=8'hA5, dout_ready=1 -> gnt=0001 same cycle; next cycle dout=A5, sel=0, dout_valid=1.
REQ-029 req=4'b1111, words 11/22/33/44, dout_ready=1 held -> dout sequence 11,22,33,44,11 on consecutive cycles, no bubble.
REQ-030 Capture word0, dout_ready=0 for 5 cycles with req=1110 -> gnt=0000, dout/sel stable; ready=1 -> next dout=word1.
REQ-031 req=0100 only, ptr=2 after capture, ready=1 -> requester 2 regranted every cycle; then req=0000 -> dout_valid drops after one cycle.
REQ-032 In HOLD, pulse rst_n low mid-cycle -> dout_valid=0, sel=0, dout=0 immediately; first grant after release goes to requester 0.
REQ-033 Every cycle: gnt one-hot or zero; gnt!=0 only when IDLE or dout_ready=1; dout unchanged while dout_valid&~dout_ready.
